// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: VGA tile reads win every cycle, CPU writes are
// posted through a small FIFO, and CPU reads wait for the FIFO to drain.
//
// state   | meaning
// IDLE    | CPU interface open; writes are posted, a read moves to RD_PEND
// RD_PEND | read latched, waiting for a cycle with no VGA request and an empty FIFO
// RD_DATA | read issued last cycle; RAM data captured into cpu_rdata_o
module vram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          vga_req_i,
    input  logic [ADDR_WIDTH-1:0]         vga_addr_i,
    output logic [DATA_WIDTH-1:0]         vga_data_o,
    input  logic                          cpu_valid_i,
    output logic                          cpu_ready_o,
    input  logic                          cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]         cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]         cpu_wdata_i,
    output logic                          cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0]         cpu_rdata_o,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count_o,
    output logic                          ram_en_o,
    output logic                          ram_we_o,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    output logic [DATA_WIDTH-1:0]         ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]         ram_rdata_i
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RD_PEND, RD_DATA} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic                  cpu_rvalid_q;
    logic                  vga_pend_q;
    logic [DATA_WIDTH-1:0] vga_data_q;

    logic [ADDR_WIDTH-1:0] wb_addr_q [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data_q [WBUF_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;

    logic fifo_empty, fifo_full, cpu_ready, push, pop, rd_issue;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(WBUF_DEPTH));
    assign cpu_ready  = (state_q == IDLE) && (cpu_we_i ? !fifo_full : 1'b1);
    assign push       = cpu_valid_i && cpu_ready && cpu_we_i;
    assign pop        = !vga_req_i && !fifo_empty;
    assign rd_issue   = !vga_req_i && fifo_empty && (state_q == RD_PEND);

    assign cpu_ready_o  = cpu_ready;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign vga_data_o   = vga_data_q;
    assign wbuf_count_o = count_q;

    // Port owner per cycle: VGA, then FIFO head, then the blocked CPU read.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (vga_req_i) begin
            ram_en_o   = 1'b1;
            ram_addr_o = vga_addr_i;
        end else if (!fifo_empty) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = wb_addr_q[rd_ptr_q];
            ram_wdata_o = wb_data_q[rd_ptr_q];
        end else if (state_q == RD_PEND) begin
            ram_en_o   = 1'b1;
            ram_addr_o = rd_addr_q;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            wb_addr_q[wr_ptr_q] <= cpu_addr_i;
            wb_data_q[wr_ptr_q] <= cpu_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vga_pend_q <= 1'b0;
            vga_data_q <= '0;
        end else begin
            vga_pend_q <= vga_req_i;
            if (vga_pend_q) vga_data_q <= ram_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_valid_i && !cpu_we_i) begin
                        rd_addr_q <= cpu_addr_i;
                        state_q   <= RD_PEND;
                    end
                end
                RD_PEND: begin
                    if (rd_issue) state_q <= RD_DATA;
                end
                RD_DATA: begin
                    cpu_rdata_q  <= ram_rdata_i;
                    cpu_rvalid_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
